booth_mult_pipe: RTL

- Parametrised, pipelined radix-4 Booth multiplier. It succeeds the combinational 16-bit signed Booth/Wallace multiplier.
- Adds generic operand width, a configurable pipeline depth, a per-transaction signed/unsigned mode, a valid/ready handshake with backpressure, and a transaction tag.
- Sits between operand-producing datapath logic and accumulators or consumers that may stall.

---
 rtl/booth_mult_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/booth_mult_pipe.sv
// booth_mult_pipe: pipelined radix-4 Booth multiplier with valid/ready
// handshake, per-transaction signed/unsigned mode and a pass-through tag.
// Optional feature macro: BOOTH_MULT_TREE_DEBUG_EN adds o_dbg_sum/o_dbg_carry,
// the final carry-save vectors aligned with o_out_valid.
//
// Stage layout (stage index 1..STAGES):
//   stage 1           : extended operands + tag (no partial products yet)
//   stages 2..STAGES-1: carry-save reduction, partial products split evenly
//   stage STAGES      : carry-propagate result (output register)
// With STAGES=1 the whole recode/reduce/add path feeds the output register.
module booth_mult_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_in_a,
    input  logic [WIDTH-1:0]     i_in_b,
    input  logic                 i_in_signed,
    input  logic [TAG_W-1:0]     i_in_tag,
    input  logic                 i_flush,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_out_result,
    output logic [TAG_W-1:0]     o_out_tag
`ifdef BOOTH_MULT_TREE_DEBUG_EN
    ,
    output logic [2*WIDTH-1:0]   o_dbg_sum,
    output logic [2*WIDTH-1:0]   o_dbg_carry
`endif
);

    localparam int NPP = WIDTH / 2 + 1;   // Booth digits for a WIDTH+1 bit operand
    localparam int PW  = 2 * WIDTH + 2;   // partial product width
    localparam int OW  = 2 * WIDTH;
`ifdef BOOTH_MULT_TREE_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    // Number of partial products already folded into the data held by stage k.
    function automatic int pp_done(input int k);
        if (k >= STAGES) return NPP;
        if (k <= 1) return 0;
        return (NPP * (k - 1)) / (STAGES - 2);
    endfunction

    // One radix-4 Booth partial product, sign-extended to PW and weighted by 4^idx.
    function automatic logic [PW-1:0] booth_pp(input logic [WIDTH:0] a,
                                               input logic [WIDTH:0] b,
                                               input int idx);
        logic [WIDTH+2:0] yy;
        logic [2:0]       sel;
        logic [PW-1:0]    m;
        logic [PW-1:0]    pp;
        yy  = {a[WIDTH], a, 1'b0};        // sign-extend to even length, append y[-1]=0
        sel = yy[2*idx +: 3];
        m   = {{(PW-WIDTH-1){b[WIDTH]}}, b};
        case (sel)
            3'b001, 3'b010: pp = m;
            3'b011:         pp = m << 1;
            3'b100:         pp = -(m << 1);
            3'b101, 3'b110: pp = -m;
            default:        pp = '0;
        endcase
        return pp << (2 * idx);
    endfunction

    // Fold partial products [lo, hi) into a sum/carry pair with 3:2 compressors.
    function automatic logic [2*PW-1:0] csa_span(input logic [PW-1:0] s_in,
                                                 input logic [PW-1:0] c_in,
                                                 input logic [WIDTH:0] a,
                                                 input logic [WIDTH:0] b,
                                                 input int lo,
                                                 input int hi);
        logic [PW-1:0] s, c, pp, t;
        s = s_in;
        c = c_in;
        for (int i = 0; i < NPP; i++) begin
            if (i >= lo && i < hi) begin
                pp = booth_pp(a, b, i);
                t  = s ^ c ^ pp;
                c  = ((s & c) | (s & pp) | (c & pp)) << 1;
                s  = t;
            end
        end
        return {s, c};
    endfunction

    logic [STAGES-1:0] r_vld;
    logic [WIDTH:0]    r_ax  [STAGES];
    logic [WIDTH:0]    r_bx  [STAGES];
    logic [PW-1:0]     r_s   [STAGES];
    logic [PW-1:0]     r_c   [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];
    logic [OW-1:0]     r_res;

    logic [STAGES-1:0] w_vld_in;
    logic [WIDTH:0]    w_ax_in  [STAGES];
    logic [WIDTH:0]    w_bx_in  [STAGES];
    logic [PW-1:0]     w_s_in   [STAGES];
    logic [PW-1:0]     w_c_in   [STAGES];
    logic [TAG_W-1:0]  w_tag_in [STAGES];
    logic [PW-1:0]     w_s_out  [STAGES];
    logic [PW-1:0]     w_c_out  [STAGES];
    logic              w_en;
    logic              w_accept;

    assign w_en         = !r_vld[STAGES-1] || i_out_ready;
    assign o_in_ready   = w_en && !i_flush;
    assign w_accept     = i_in_valid && o_in_ready;
    assign o_out_valid  = r_vld[STAGES-1];
    assign o_out_result = r_res;
    assign o_out_tag    = r_tag[STAGES-1];
`ifdef BOOTH_MULT_TREE_DEBUG_EN
    assign o_dbg_sum    = r_s[STAGES-1][OW-1:0];
    assign o_dbg_carry  = r_c[STAGES-1][OW-1:0];
`endif

    // Stage inputs and the carry-save work each stage performs before its register.
    always_comb begin
        w_vld_in[0] = w_accept;
        w_ax_in[0]  = {i_in_signed & i_in_a[WIDTH-1], i_in_a};
        w_bx_in[0]  = {i_in_signed & i_in_b[WIDTH-1], i_in_b};
        w_s_in[0]   = '0;
        w_c_in[0]   = '0;
        w_tag_in[0] = i_in_tag;
        for (int k = 1; k < STAGES; k++) begin
            w_vld_in[k] = r_vld[k-1];
            w_ax_in[k]  = r_ax[k-1];
            w_bx_in[k]  = r_bx[k-1];
            w_s_in[k]   = r_s[k-1];
            w_c_in[k]   = r_c[k-1];
            w_tag_in[k] = r_tag[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            {w_s_out[k], w_c_out[k]} = csa_span(w_s_in[k], w_c_in[k], w_ax_in[k], w_bx_in[k],
                                                pp_done(k), pp_done(k + 1));
        end
    end

    // Valid bits: shift on advance, cleared by flush regardless of advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld <= w_vld_in;
        end
    end

    // Data registers shift with the valid bits; final stage holds the CPA result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ax[k]  <= '0;
                r_bx[k]  <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= '0;
                r_tag[k] <= '0;
            end
            r_res <= '0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ax[k]  <= w_ax_in[k];
                r_bx[k]  <= w_bx_in[k];
                r_tag[k] <= w_tag_in[k];
                // last-stage sum/carry only exist to feed the debug outputs
                if (k < STAGES - 1 || DBG) begin
                    r_s[k] <= w_s_out[k];
                    r_c[k] <= w_c_out[k];
                end
            end
            r_res <= w_s_out[STAGES-1][OW-1:0] + w_c_out[STAGES-1][OW-1:0];
        end
    end

endmodule
